// File: rtl/regfile_wport_arb_pkg.sv
// Shared register-file constants for the write-port arbiter slice.
package regfile_wport_arb_pkg;
  localparam int unsigned       RegBus      = 32;
  localparam int unsigned       RegAddrBus  = 5;
  localparam int unsigned       RegNum      = 1 << RegAddrBus;
  localparam logic              RstEnable   = 1'b1;
  localparam logic              WriteEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord    = '0;
  localparam int unsigned       StarveLimit = 4;
endpackage

// File: rtl/regfile_wport_arb_wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned   PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW     = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (cnt_q == DepthC);
    empty    = (cnt_q == '0);
    head     = mem_q[rd_ptr_q];
    // full is taken from the registered count, so a pop does not open a slot this cycle
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/regfile_wport_arb.sv
// Regfile write-port arbiter: pipeline writeback wins, long-latency results queue,
// with a busy scoreboard for RAW hazards and a starvation bubble request.
module regfile_wport_arb
  import regfile_wport_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = RegBus,
  parameter int unsigned ADDR_W       = RegAddrBus,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = StarveLimit
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_waddr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              iss_vld,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              hazard,
  output logic              stall_req,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);
  localparam int unsigned   NREG       = 1 << ADDR_W;
  localparam int unsigned   EW         = ADDR_W + DATA_W;
  localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveLast = SW'(STARVE_LIMIT - 1);

  logic              in_rst, b_commit;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_din, fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_req_q, stall_req_d;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (b_commit),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    in_rst                 = (rst == RstEnable);
    {head_addr, head_data} = fifo_head;
    b_ready                = !in_rst && !fifo_full;
    // results for r0 are acknowledged but never buffered
    fifo_push              = b_valid && b_ready && (b_waddr != '0);
    fifo_din               = {b_waddr, b_wdata};
    b_commit               = !in_rst && !a_we && !fifo_empty;

    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!in_rst && a_we) begin
      we    = WriteEnable;
      waddr = a_waddr;
      wdata = a_wdata;
    end else if (b_commit) begin
      we    = WriteEnable;
      waddr = head_addr;
      wdata = head_data;
    end

    busy_d = busy_q;
    if (b_commit) busy_d[head_addr] = 1'b0;
    if (iss_vld && iss_addr != '0) busy_d[iss_addr] = 1'b1;

    // a register committing this cycle is forwarded by the regfile, so it does not stall
    hazard = 1'b0;
    if (!in_rst) begin
      if (chk_addr1 != '0 && busy_q[chk_addr1] && !(b_commit && head_addr == chk_addr1))
        hazard = 1'b1;
      if (chk_addr2 != '0 && busy_q[chk_addr2] && !(b_commit && head_addr == chk_addr2))
        hazard = 1'b1;
    end

    starve_d    = '0;
    stall_req_d = 1'b0;
    if (a_we && !fifo_empty) begin
      if (starve_q == StarveLast) stall_req_d = 1'b1;
      else                        starve_d    = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      starve_q    <= '0;
      stall_req_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      starve_q    <= starve_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign stall_req = stall_req_q;
endmodule
